hls_srl_fifo_ctrl: RTL and testbench

//  Parametrised SRL-based FIFO for inter-PE streams and start tokens in the Linear_Layer dataflow.

---
 rtl/hls_fifo_pkg.sv | 23 ++
 rtl/hls_srl_fifo_store.sv | 25 ++
 rtl/hls_srl_fifo_ctrl.sv | 105 ++++++++++
 tb/tb_hls_srl_fifo_ctrl.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/hls_fifo_pkg.sv
// Shared types and elaboration helpers for the SRL-based HLS stream FIFO.
package hls_fifo_pkg;

  typedef struct packed {
    logic full_n;
    logic empty_n;
    logic almost_full;
    logic almost_empty;
  } flags_t;

  localparam flags_t FLAGS_RST = '{full_n: 1'b1, empty_n: 1'b0,
                                   almost_full: 1'b0, almost_empty: 1'b1};

  // Occupancy must represent 0..DEPTH inclusive.
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic bit addr_fits(input int aw, input int depth);
    return (64'd1 << aw) >= 64'(depth);
  endfunction

endpackage

// File: rtl/hls_srl_fifo_store.sv
// Shift-on-write addressable store; no reset so it maps onto SRL primitives.
module hls_srl_fifo_store #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4,
  parameter int DEPTH      = 16
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout
);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[0] <= din;
      for (int i = 1; i < DEPTH; i++) r_mem[i] <= r_mem[i-1];
    end
  end

  assign dout = r_mem[addr];

endmodule

// File: rtl/hls_srl_fifo_ctrl.sv
// SRL FIFO controller: occupancy count, registered flags, optional output register.
// Macro HLS_SRL_FIFO_OREG_EN enables the registered output stage (prefetched head entry).
module hls_srl_fifo_ctrl
  import hls_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4,
  parameter int DEPTH      = 16,
  parameter int AF_LEVEL   = 14,
  parameter int AE_LEVEL   = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  if_write,
  input  logic [DATA_WIDTH-1:0] if_din,
  output logic                  if_full_n,
  input  logic                  if_read,
  output logic [DATA_WIDTH-1:0] if_dout,
  output logic                  if_empty_n,
  output logic [ADDR_WIDTH:0]   if_num_data_valid,
  output logic                  if_almost_full,
  output logic                  if_almost_empty
);

  localparam int CW = cnt_width(DEPTH);

  if (!addr_fits(ADDR_WIDTH, DEPTH)) begin : g_addr_check
    $error("hls_srl_fifo_ctrl: 2**ADDR_WIDTH must be >= DEPTH");
  end

  flags_t                r_flags, w_flags_nxt;
  logic [CW-1:0]         r_count, w_count_nxt;
  logic                  w_wr_acc, w_rd_acc, w_we, w_empty_n_nxt;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [DATA_WIDTH-1:0] w_store_dout;

  assign w_wr_acc    = if_write & r_flags.full_n;
  assign w_rd_acc    = if_read & r_flags.empty_n;
  assign w_we        = w_wr_acc & ~reset;
  assign w_count_nxt = r_count + CW'(w_wr_acc) - CW'(w_rd_acc);

  always_comb begin
    w_flags_nxt.full_n       = (w_count_nxt != CW'(DEPTH));
    w_flags_nxt.empty_n      = w_empty_n_nxt;
    w_flags_nxt.almost_full  = (w_count_nxt >= CW'(AF_LEVEL));
    w_flags_nxt.almost_empty = (w_count_nxt <= CW'(AE_LEVEL));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
      r_flags <= FLAGS_RST;
    end else begin
      r_count <= w_count_nxt;
      r_flags <= w_flags_nxt;
    end
  end

  hls_srl_fifo_store #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH),
    .DEPTH     (DEPTH)
  ) u_store (
    .clk (clk),
    .we  (w_we),
    .addr(w_addr),
    .din (if_din),
    .dout(w_store_dout)
  );

`ifdef HLS_SRL_FIFO_OREG_EN
  // empty_n doubles as the output-register valid bit.
  logic [CW-1:0]         r_scnt, w_scnt_nxt;
  logic                  w_pop;
  logic [DATA_WIDTH-1:0] r_dout;

  assign w_pop         = (r_scnt != '0) && (!r_flags.empty_n || w_rd_acc);
  assign w_scnt_nxt    = r_scnt + CW'(w_wr_acc) - CW'(w_pop);
  assign w_addr        = ADDR_WIDTH'(r_scnt - CW'(1));
  assign w_empty_n_nxt = w_pop | (r_flags.empty_n & ~w_rd_acc);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_scnt <= '0;
      r_dout <= '0;
    end else begin
      r_scnt <= w_scnt_nxt;
      if (w_pop) r_dout <= w_store_dout;
    end
  end

  assign if_dout = r_dout;
`else
  assign w_addr        = ADDR_WIDTH'(r_count - CW'(1));
  assign w_empty_n_nxt = (w_count_nxt != '0);
  assign if_dout       = w_store_dout;
`endif

  assign if_full_n         = r_flags.full_n;
  assign if_empty_n        = r_flags.empty_n;
  assign if_almost_full    = r_flags.almost_full;
  assign if_almost_empty   = r_flags.almost_empty;
  assign if_num_data_valid = (ADDR_WIDTH+1)'(r_count);

endmodule

// File: tb/tb_hls_srl_fifo_ctrl.sv
// Directed bench for hls_srl_fifo_ctrl; works with or without HLS_SRL_FIFO_OREG_EN.
module tb_hls_srl_fifo_ctrl;

  localparam int DW    = 32;
  localparam int AW    = 4;
  localparam int DEPTH = 16;
`ifdef HLS_SRL_FIFO_OREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic          clk = 1'b0;
  logic          reset, if_write, if_read;
  logic [DW-1:0] if_din, if_dout;
  logic          if_full_n, if_empty_n, if_almost_full, if_almost_empty;
  logic [AW:0]   if_num_data_valid;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  hls_srl_fifo_ctrl #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .AF_LEVEL(14), .AE_LEVEL(2)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .if_write         (if_write),
    .if_din           (if_din),
    .if_full_n        (if_full_n),
    .if_read          (if_read),
    .if_dout          (if_dout),
    .if_empty_n       (if_empty_n),
    .if_num_data_valid(if_num_data_valid),
    .if_almost_full   (if_almost_full),
    .if_almost_empty  (if_almost_empty)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; if_write = 1'b0; if_read = 1'b0; if_din = '0;
    tick(); tick();
    chk("rst_full_n", 32'(if_full_n), 1);
    chk("rst_empty_n", 32'(if_empty_n), 0);
    chk("rst_count", 32'(if_num_data_valid), 0);
    chk("rst_af", 32'(if_almost_full), 0);
    chk("rst_ae", 32'(if_almost_empty), 1);
`ifdef HLS_SRL_FIFO_OREG_EN
    chk("rst_dout", if_dout, 0);
`endif
    reset = 1'b0;

    // Test 1: fill with 0x00..0x0F, then an ignored 17th write
    for (int i = 0; i < 16; i++) begin
      if_write = 1'b1; if_din = 32'(i);
      tick();
      chk("t1_count", 32'(if_num_data_valid), 32'(i + 1));
      chk("t1_empty_n", 32'(if_empty_n), 32'(i >= LAT - 1));
      chk("t1_af", 32'(if_almost_full), 32'(i + 1 >= 14));
      chk("t1_full_n", 32'(if_full_n), 32'(i + 1 != 16));
    end
    if_din = 32'h55;
    tick();
    if_write = 1'b0;
    chk("t1_ovf_count", 32'(if_num_data_valid), 16);
    chk("t1_ovf_full_n", 32'(if_full_n), 0);

    // Test 2: drain 16 entries in order, then an ignored read at empty
    for (int j = 0; j < 16; j++) begin
      chk("t2_dout", if_dout, 32'(j));
      if_read = 1'b1;
      tick();
      chk("t2_count", 32'(if_num_data_valid), 32'(15 - j));
      chk("t2_empty_n", 32'(if_empty_n), 32'(j != 15));
      chk("t2_ae", 32'(if_almost_empty), 32'(15 - j <= 2));
      chk("t2_af", 32'(if_almost_full), 32'(15 - j >= 14));
      chk("t2_full_n", 32'(if_full_n), 1);
    end
    tick();
    if_read = 1'b0;
    chk("t2_udf_count", 32'(if_num_data_valid), 0);
    chk("t2_udf_empty_n", 32'(if_empty_n), 0);

    // Test 3: hold occupancy at 5 under continuous read+write
    for (int k = 0; k < 5; k++) begin
      if_write = 1'b1; if_din = 32'h100 + 32'(k);
      tick();
    end
    if_write = 1'b0;
    tick();
    chk("t3_fill_count", 32'(if_num_data_valid), 5);
    for (int c = 0; c < 100; c++) begin
      chk("t3_dout", if_dout, (c < 5) ? 32'h100 + 32'(c) : 32'h200 + 32'(c - 5));
      if_write = 1'b1; if_read = 1'b1; if_din = 32'h200 + 32'(c);
      tick();
      chk("t3_count", 32'(if_num_data_valid), 5);
      chk("t3_empty_n", 32'(if_empty_n), 1);
    end
    if_write = 1'b0; if_read = 1'b0;
    chk("t3_head", if_dout, 32'h25F);

    // Test 4: at full, read+write with 0xAA -> only the read is taken
    for (int k = 0; k < 11; k++) begin
      if_write = 1'b1; if_din = 32'h300 + 32'(k);
      tick();
    end
    if_write = 1'b0;
    chk("t4_full_count", 32'(if_num_data_valid), 16);
    chk("t4_full_n", 32'(if_full_n), 0);
    if_write = 1'b1; if_read = 1'b1; if_din = 32'hAA;
    tick();
    if_write = 1'b0; if_read = 1'b0;
    chk("t4_rw_count", 32'(if_num_data_valid), 15);
    chk("t4_rw_full_n", 32'(if_full_n), 1);
    for (int k = 0; k < 15; k++) begin
      chk("t4_dout", if_dout, (k < 4) ? 32'h260 + 32'(k) : 32'h300 + 32'(k - 4));
      if_read = 1'b1;
      tick();
    end
    if_read = 1'b0;
    chk("t4_end_count", 32'(if_num_data_valid), 0);

    // Test 5: reset at count 9 with a concurrent write that must be lost
    for (int k = 0; k < 9; k++) begin
      if_write = 1'b1; if_din = 32'h400 + 32'(k);
      tick();
    end
    chk("t5_pre_count", 32'(if_num_data_valid), 9);
    reset = 1'b1; if_din = 32'h77;
    tick();
    reset = 1'b0; if_write = 1'b0;
    chk("t5_count", 32'(if_num_data_valid), 0);
    chk("t5_empty_n", 32'(if_empty_n), 0);
    chk("t5_full_n", 32'(if_full_n), 1);
    chk("t5_ae", 32'(if_almost_empty), 1);
    chk("t5_af", 32'(if_almost_full), 0);
`ifdef HLS_SRL_FIFO_OREG_EN
    chk("t5_dout", if_dout, 0);
`endif
    tick();
    chk("t5_lost_count", 32'(if_num_data_valid), 0);

    // Read+write at empty: only the write is accepted
    if_write = 1'b1; if_read = 1'b1; if_din = 32'h88;
    tick();
    if_write = 1'b0; if_read = 1'b0;
    chk("t5_rwe_count", 32'(if_num_data_valid), 1);
    chk("t5_rwe_empty_n", 32'(if_empty_n), 32'(LAT == 1));
    for (int w = 1; w < LAT; w++) tick();
    chk("t5_rwe_empty_n_late", 32'(if_empty_n), 1);
    chk("t5_rwe_dout", if_dout, 32'h88);
    if_read = 1'b1;
    tick();
    if_read = 1'b0;
    chk("t5_final_count", 32'(if_num_data_valid), 0);
    chk("t5_final_empty_n", 32'(if_empty_n), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
